// File: rtl/vga_timing_out.sv
// VGA raster timing generator: pixel divider, h/v counters, registered syncs and blanked colour.
// Optional `VGA_BORDER_TEST_EN forces white on the outermost visible pixels for monitor alignment.
module vga_timing_out #(
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FP      = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BP      = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FP      = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BP      = 33,
    parameter int unsigned CLK_DIV   = 2,
    parameter bit          SYNC_POL  = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       r_buf,
    input  logic       g_buf,
    input  logic       b_buf,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       video_on,
    output logic       pixel_tick,
    output logic       frame_tick,
    output logic       hsync,
    output logic       vsync,
    output logic       red,
    output logic       green,
    output logic       blue
);
    localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FP + V_SYNC - 1);

    logic [DIV_W-1:0] div_reg, div_next;
    logic             tick_reg;
    logic [9:0]       x_reg, x_next;
    logic [9:0]       y_reg, y_next;
    logic             hsync_reg, vsync_reg;
    logic [2:0]       rgb_reg, rgb_next, rgb_in;
    logic             hs_raw, vs_raw, line_end;

    assign div_next = (div_reg == DIV_LAST) ? '0 : div_reg + DIV_W'(1);
    assign line_end = (x_reg == H_LAST);

    always_comb begin
        x_next = x_reg;
        y_next = y_reg;
        if (tick_reg) begin
            if (line_end) begin
                x_next = '0;
                y_next = (y_reg == V_LAST) ? '0 : y_reg + 10'd1;
            end else begin
                x_next = x_reg + 10'd1;
            end
        end
    end

    assign video_on   = (x_reg < H_VIS) && (y_reg < V_VIS);
    assign hs_raw     = (x_reg >= HS_FIRST) && (x_reg <= HS_LAST);
    assign vs_raw     = (y_reg >= VS_FIRST) && (y_reg <= VS_LAST);
    assign frame_tick = tick_reg && line_end && (y_reg == V_LAST);
    assign rgb_in     = {r_buf, g_buf, b_buf};

`ifdef VGA_BORDER_TEST_EN
    logic border;
    assign border = video_on && ((x_reg == 10'd0) || (x_reg == H_VIS - 10'd1) ||
                                 (y_reg == 10'd0) || (y_reg == V_VIS - 10'd1));
`endif

    // Colour is gated by the counters of the pixel being registered, so blanking stays aligned with sync.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_colour
`ifdef VGA_BORDER_TEST_EN
            assign rgb_next[gi] = (rgb_in[gi] & video_on) | border;
`else
            assign rgb_next[gi] = rgb_in[gi] & video_on;
`endif
        end
    endgenerate

    // tick_reg is high exactly while the divider sits at its last count.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_reg   <= '0;
            tick_reg  <= 1'b0;
            x_reg     <= '0;
            y_reg     <= '0;
            hsync_reg <= ~SYNC_POL;
            vsync_reg <= ~SYNC_POL;
            rgb_reg   <= '0;
        end else begin
            div_reg  <= div_next;
            tick_reg <= (div_next == DIV_LAST);
            x_reg    <= x_next;
            y_reg    <= y_next;
            if (tick_reg) begin
                hsync_reg <= hs_raw ? SYNC_POL : ~SYNC_POL;
                vsync_reg <= vs_raw ? SYNC_POL : ~SYNC_POL;
                rgb_reg   <= rgb_next;
            end
        end
    end

    assign pixel_x    = x_reg;
    assign pixel_y    = y_reg;
    assign pixel_tick = tick_reg;
    assign hsync      = hsync_reg;
    assign vsync      = vsync_reg;
    assign red        = rgb_reg[2];
    assign green      = rgb_reg[1];
    assign blue       = rgb_reg[0];
endmodule

// File: tb/tb_vga_timing_out.sv
// Bench for vga_timing_out with a shrunken raster (25x17 pixels, CLK_DIV=2) so whole frames fit in a short run.
module tb_vga_timing_out;
    localparam int HV = 16, HF = 2, HS = 4, HB = 3, HT = HV + HF + HS + HB;
    localparam int VV = 10, VF = 2, VS = 2, VB = 3, VT = VV + VF + VS + VB;
    localparam int D  = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       r_buf = 1'b0, g_buf = 1'b0, b_buf = 1'b0;
    logic [9:0] pixel_x, pixel_y;
    logic       video_on, pixel_tick, frame_tick, hsync, vsync, red, green, blue;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vga_timing_out #(
        .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .CLK_DIV(D), .SYNC_POL(1'b0)
    ) dut (
        .clk(clk), .reset(reset),
        .r_buf(r_buf), .g_buf(g_buf), .b_buf(b_buf),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .video_on(video_on),
        .pixel_tick(pixel_tick), .frame_tick(frame_tick),
        .hsync(hsync), .vsync(vsync), .red(red), .green(green), .blue(blue)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    function automatic bit border_px(input int x, input int y);
`ifdef VGA_BORDER_TEST_EN
        return (x == 0) || (x == HV - 1) || (y == 0) || (y == VV - 1);
`else
        return 1'b0;
`endif
    endfunction

    // Model: n_m = clock edges since reset released; everything else is arithmetic on it.
    int       n_m = 0;
    logic [2:0] cap_m = 3'b000;
    bit       model_valid = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            n_m <= 0;
            model_valid <= 1'b1;
        end else begin
            if (n_m % D == D - 1) cap_m <= {r_buf, g_buf, b_buf};
            n_m <= n_m + 1;
        end
    end

    always @(negedge clk) begin
        int p, x, y, q, qx, qy;
        bit tk, vis;
        logic exp_hs, exp_vs;
        logic [2:0] exp_rgb;
        if (model_valid) begin
            p   = n_m / D;
            x   = p % HT;
            y   = (p / HT) % VT;
            tk  = (n_m % D == D - 1);
            vis = (x < HV) && (y < VV);
            if (p == 0) begin
                exp_hs = 1'b1; exp_vs = 1'b1; exp_rgb = 3'b000;
            end else begin
                q  = p - 1;
                qx = q % HT;
                qy = (q / HT) % VT;
                exp_hs = !((qx >= HV + HF) && (qx < HV + HF + HS));
                exp_vs = !((qy >= VV + VF) && (qy < VV + VF + VS));
                if ((qx < HV) && (qy < VV))
                    exp_rgb = border_px(qx, qy) ? 3'b111 : cap_m;
                else
                    exp_rgb = 3'b000;
            end
            check("pixel_x", 32'(pixel_x), 32'(x));
            check("pixel_y", 32'(pixel_y), 32'(y));
            check("pixel_tick", 32'(pixel_tick), 32'(tk));
            check("video_on", 32'(video_on), 32'(vis));
            check("frame_tick", 32'(frame_tick), 32'(tk && x == HT - 1 && y == VT - 1));
            check("hsync", 32'(hsync), 32'(exp_hs));
            check("vsync", 32'(vsync), 32'(exp_vs));
            check("rgb", 32'({red, green, blue}), 32'(exp_rgb));
        end
    end

    // Measurement window: index 0 is the first negedge after reset release.
    int m_hfall0, m_hfall1, m_hlow, m_vfall0, m_vlow, m_ft0, m_ft1, m_ftcnt, m_ticks, m_red;
    logic [9:0] m_x0;
    logic m_hs0, m_tick0, m_red0;

    task automatic measure(input int ncyc);
        logic prev_h, prev_v;
        m_hfall0 = -1; m_hfall1 = -1; m_vfall0 = -1; m_ft0 = -1; m_ft1 = -1;
        m_hlow = 0; m_vlow = 0; m_ftcnt = 0; m_ticks = 0; m_red = 0;
        prev_h = 1'b1; prev_v = 1'b1;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (i == 0) begin
                m_x0 = pixel_x; m_hs0 = hsync; m_tick0 = pixel_tick; m_red0 = red;
            end
            if (prev_h && !hsync) begin
                if (m_hfall0 < 0) m_hfall0 = i;
                else if (m_hfall1 < 0) m_hfall1 = i;
            end
            if (prev_v && !vsync && m_vfall0 < 0) m_vfall0 = i;
            if (!hsync) m_hlow++;
            if (!vsync) m_vlow++;
            if (pixel_tick) m_ticks++;
            if (red) m_red++;
            if (frame_tick) begin
                if (m_ftcnt == 0) m_ft0 = i;
                else if (m_ftcnt == 1) m_ft1 = i;
                m_ftcnt++;
            end
            prev_h = hsync;
            prev_v = vsync;
        end
    endtask

    initial begin
        bit found;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_hsync", 32'(hsync), 32'd1);
        check("reset_vsync", 32'(vsync), 32'd1);
        check("reset_rgb", 32'({red, green, blue}), 32'd0);
        check("reset_pixel_x", 32'(pixel_x), 32'd0);
        check("reset_tick", 32'(pixel_tick), 32'd0);

        // Two full frames with white input.
        @(posedge clk); #1;
        reset = 1'b0;
        {r_buf, g_buf, b_buf} = 3'b111;
        measure(2 * HT * VT * D);
        $display("frames 1-2: hfall %0d/%0d ft %0d/%0d vfall %0d red %0d", m_hfall0, m_hfall1, m_ft0, m_ft1, m_vfall0, m_red);
        check("first_tick_clk0", 32'(m_tick0), 32'd0);
        check("tick_count", 32'(m_ticks), 32'd850);
        check("hsync_first_fall", 32'(m_hfall0), 32'd38);
        check("hsync_period", 32'(m_hfall1 - m_hfall0), 32'd50);
        check("hsync_low_clks", 32'(m_hlow), 32'd272);
        check("vsync_first_fall", 32'(m_vfall0), 32'd602);
        check("vsync_low_clks", 32'(m_vlow), 32'd200);
        check("frame_tick_count", 32'(m_ftcnt), 32'd2);
        check("frame_tick_first", 32'(m_ft0), 32'd849);
        check("frame_tick_period", 32'(m_ft1 - m_ft0), 32'd850);
        check("red_clks_white", 32'(m_red), 32'd640);

        // Black input, then reset mid-line while hsync is low.
        {r_buf, g_buf, b_buf} = 3'b000;
        found = 1'b0;
        for (int i = 0; i < 4 * HT * VT * D && !found; i++) begin
            @(negedge clk);
            if (pixel_x == 10'd19 && pixel_y == 10'd5) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL wait_x19_y5: got timeout expected position reached");
        end else begin
            check("hsync_low_before_reset", 32'(hsync), 32'd0);
            @(posedge clk); #1;
            reset = 1'b1;
            @(posedge clk); #1;
            reset = 1'b0;
            measure(HT * VT * D);
            $display("after reset: x0 %0d hs0 %0d hfall %0d ft %0d red %0d", m_x0, m_hs0, m_hfall0, m_ft0, m_red);
            check("rst_pixel_x", 32'(m_x0), 32'd0);
            check("rst_hsync_high", 32'(m_hs0), 32'd1);
            check("rst_rgb", 32'(m_red0), 32'd0);
            check("rst_hsync_first_fall", 32'(m_hfall0), 32'd38);
            check("rst_frame_tick_first", 32'(m_ft0), 32'd849);
`ifdef VGA_BORDER_TEST_EN
            check("red_clks_black", 32'(m_red), 32'd96);
`else
            check("red_clks_black", 32'(m_red), 32'd0);
`endif
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
